// File: rtl/gray_counter_param_if.sv
// Control and result bundle for gray_counter_param; the counter sits on the slave side.
// Latency: none, wires only. Backpressure: none, the counter accepts a command every cycle.
// Set WIDTH to match the counter it connects to.
interface gray_counter_param_if #(
    parameter int WIDTH = 3
) ();
    logic             En;
    logic             Dir;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic             ClrOvf;
    logic [WIDTH-1:0] Output;
    logic [WIDTH-1:0] Binary;
    logic             Overflow;
    logic             Wrap;

    modport master (
        output En, Dir, Load, LoadVal, ClrOvf,
        input  Output, Binary, Overflow, Wrap
    );

    modport slave (
        input  En, Dir, Load, LoadVal, ClrOvf,
        output Output, Binary, Overflow, Wrap
    );
endinterface

// File: rtl/gray_counter_param.sv
// Up/down Gray counter with load, sticky overflow and a wrap pulse. GRAY_SAT_EN selects saturation instead of wrap.
// Latency: one edge from command to count; Output and Binary are combinational from the count register.
// Backpressure: none, one step per enabled cycle.
module gray_counter_param #(
    parameter int          WIDTH = 3,
    parameter int unsigned INIT  = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    gray_counter_param_if.slave  bus
);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_min, wrap_step;

    // Count is kept in binary so stepping is a plain add; Gray is derived on the way out.
    always_comb begin
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        wrap_d    = 1'b0;
        at_max    = &cnt_q;
        at_min    = ~|cnt_q;
        wrap_step = !bus.Load && bus.En && (bus.Dir ? at_max : at_min);

        if (bus.ClrOvf) begin
            ovf_d = 1'b0;
        end

        if (bus.Load) begin
            cnt_d = bus.LoadVal;
        end else if (bus.En) begin
`ifdef GRAY_SAT_EN
            if (!wrap_step) begin
                cnt_d = bus.Dir ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
            end
`else
            cnt_d = bus.Dir ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
`endif
        end

        // A wrap attempt beats a same-cycle clear of the sticky flag.
        if (wrap_step) begin
            ovf_d = 1'b1;
`ifdef GRAY_SAT_EN
            wrap_d = 1'b0;
`else
            wrap_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q  <= INIT_V;
            ovf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.Binary   = cnt_q;
    assign bus.Output   = cnt_q ^ (cnt_q >> 1);
    assign bus.Overflow = ovf_q;
    assign bus.Wrap     = wrap_q;
endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench for gray_counter_param: a 3-bit and a 4-bit instance on one clock.
// Expectations follow the GRAY_SAT_EN setting of the build.
module tb_gray_counter_param;
`ifdef GRAY_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic Clk;
    logic rst3, rst4;
    int   n_checks = 0;
    int   n_fail   = 0;

    gray_counter_param_if #(.WIDTH(3)) b3 ();
    gray_counter_param_if #(.WIDTH(4)) b4 ();

    gray_counter_param #(.WIDTH(3), .INIT(0)) u3 (.Clk(Clk), .Reset(rst3), .bus(b3));
    gray_counter_param #(.WIDTH(4), .INIT(0)) u4 (.Clk(Clk), .Reset(rst4), .bus(b4));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [2:0] gray3 [8];
        int         bin;
        gray3 = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

        rst3 = 1'b1; rst4 = 1'b1;
        b3.En = 0; b3.Dir = 0; b3.Load = 0; b3.LoadVal = '0; b3.ClrOvf = 0;
        b4.En = 0; b4.Dir = 0; b4.Load = 0; b4.LoadVal = '0; b4.ClrOvf = 0;
        #12;
        check("rst_out3",  32'(b3.Output),   0);
        check("rst_ovf3",  32'(b3.Overflow), 0);
        check("rst_wrap3", 32'(b3.Wrap),     0);
        check("rst_bin4",  32'(b4.Binary),   0);
        rst3 = 1'b0; rst4 = 1'b0;

        // Count up ten steps through (or into) the top of the range.
        b3.En = 1; b3.Dir = 1;
        for (int i = 1; i <= 10; i++) begin
            step();
            bin = SAT ? ((i > 7) ? 7 : i) : (i % 8);
            check("up_bin",  32'(b3.Binary),   bin);
            check("up_gray", 32'(b3.Output),   32'(gray3[bin]));
            check("up_wrap", 32'(b3.Wrap),     32'(!SAT && i == 8));
            check("up_ovf",  32'(b3.Overflow), 32'(i >= 8));
        end
        b3.Dir = 0;
        step();
        check("dn_after", 32'(b3.Binary), SAT ? 6 : 1);
        check("dn_wrap0", 32'(b3.Wrap),   0);

        b3.En = 0; b3.ClrOvf = 1;
        step();
        check("clr_ovf", 32'(b3.Overflow), 0);
        b3.ClrOvf = 0; b3.Load = 1; b3.LoadVal = 3'd0;
        step();
        b3.Load = 0; b3.En = 1; b3.Dir = 0; b3.ClrOvf = 1;
        step();
        check("clrwrap_bin",  32'(b3.Binary),   SAT ? 0 : 7);
        check("clrwrap_ovf",  32'(b3.Overflow), 1);
        check("clrwrap_wrap", 32'(b3.Wrap),     32'(!SAT));
        b3.En = 0; b3.ClrOvf = 0;
        step();
        check("wrap_pulse_end", 32'(b3.Wrap),     0);
        check("ovf_sticky",     32'(b3.Overflow), 1);

        // 4-bit: down from zero, then straight back up.
        b4.En = 1; b4.Dir = 0;
        step();
        check("w4_dn_bin",  32'(b4.Binary),   SAT ? 0 : 15);
        check("w4_dn_gray", 32'(b4.Output),   SAT ? 0 : 32'b1000);
        check("w4_dn_wrap", 32'(b4.Wrap),     32'(!SAT));
        check("w4_dn_ovf",  32'(b4.Overflow), 1);
        b4.Dir = 1;
        step();
        check("w4_up_bin",  32'(b4.Binary), SAT ? 1 : 0);
        check("w4_up_gray", 32'(b4.Output), SAT ? 1 : 0);
        check("w4_up_wrap", 32'(b4.Wrap),   32'(!SAT));

        b4.Load = 1; b4.LoadVal = 4'd9;
        step();
        check("ld9_bin",  32'(b4.Binary), 9);
        check("ld9_gray", 32'(b4.Output), 32'b1101);
        check("ld9_wrap", 32'(b4.Wrap),   0);
        b4.Load = 0;
        step();
        check("inc10_bin",  32'(b4.Binary), 10);
        check("inc10_gray", 32'(b4.Output), 32'b1111);

        // Load at all-ones with clear, then load beats a would-be wrap step.
        b4.En = 0; b4.Load = 1; b4.LoadVal = 4'd15; b4.ClrOvf = 1;
        step();
        check("ld15_bin", 32'(b4.Binary),   15);
        check("ld15_ovf", 32'(b4.Overflow), 0);
        b4.ClrOvf = 0; b4.En = 1; b4.Dir = 1; b4.LoadVal = 4'd3;
        step();
        check("ldpri_bin",  32'(b4.Binary),   3);
        check("ldpri_wrap", 32'(b4.Wrap),     0);
        check("ldpri_ovf",  32'(b4.Overflow), 0);
        b4.Load = 0; b4.En = 0;
        step();
        check("hold_bin", 32'(b4.Binary), 3);

        // Asynchronous reset mid-cycle while holding a nonzero count.
        b3.Load = 1; b3.LoadVal = 3'd3; b3.En = 0;
        step();
        b3.Load = 0; b3.En = 1; b3.Dir = 1;
        step();
        step();
        check("pre_rst_bin", 32'(b3.Binary), 5);
        b3.En = 0;
        #2;
        rst3 = 1'b1;
        #1;
        check("arst_gray", 32'(b3.Output),   0);
        check("arst_bin",  32'(b3.Binary),   0);
        check("arst_ovf",  32'(b3.Overflow), 0);
        check("arst_wrap", 32'(b3.Wrap),     0);
        step();
        rst3 = 1'b0;
        b3.En = 1; b3.Dir = 1;
        step();
        check("post_rst_bin", 32'(b3.Binary), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
